// File: rtl/fir_tdm_sched.sv
// fir_tdm_sched: one 3-tap FIR multiply-accumulate datapath shared by NCH
// sample channels. Each channel keeps its own delay line, the coefficient
// set is shared, requests are granted round-robin and each result is
// returned with its channel tag over a valid/ready output.
// Optional build macro FIR_TDM_SAT_EN: saturate the 18-bit accumulator to
// 16-bit signed on output; without it the low 16 bits are returned (wrap).
module fir_tdm_sched #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [8*NCH-1:0]     in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHW-1:0]       out_ch,
  output logic [15:0]          out_data,
  input  logic                 coef_wr_en,
  input  logic [1:0]           coef_wr_addr,
  input  logic [7:0]           coef_wr_data,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC0 = 3'd1,
    MAC1 = 3'd2,
    MAC2 = 3'd3,
    OUTS = 3'd4
  } state_t;

  state_t                state_r;
  logic signed [7:0]     x0_r [NCH];
  logic signed [7:0]     x1_r [NCH];
  logic signed [7:0]     x2_r [NCH];
  logic signed [7:0]     c0_r;
  logic signed [7:0]     c1_r;
  logic signed [7:0]     c2_r;
  logic [CHW-1:0]        last_r;
  logic [CHW-1:0]        ch_r;
  logic signed [17:0]    acc_r;

  logic [CHW-1:0]        grant_s;
  logic                  found_s;
  logic                  hs_s;
  logic signed [7:0]     mul_x_s;
  logic signed [7:0]     mul_c_s;
  logic signed [15:0]    prod_s;
  logic signed [17:0]    sum_s;

  // Channel index reached by stepping 'off' places past 'base' with wrap.
  function automatic logic [CHW-1:0] wrap_idx(input logic [CHW-1:0] base, input int off);
    int t;
    t = (int'(base) + off) % NCH;
    return t[CHW-1:0];
  endfunction

`ifdef FIR_TDM_SAT_EN
  // Clamp the accumulator into the 16-bit signed range.
  function automatic logic [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767) begin
      return 16'h7FFF;
    end else if (v < -18'sd32768) begin
      return 16'h8000;
    end else begin
      return v[15:0];
    end
  endfunction
`endif

  // Round-robin search for the first requesting channel after the last grant.
  always_comb begin
    grant_s = {CHW{1'b0}};
    found_s = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      if (!found_s && in_valid[wrap_idx(last_r, i)]) begin
        found_s = 1'b1;
        grant_s = wrap_idx(last_r, i);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Accept strobe for the granted channel; only offered while idle.
  always_comb begin
    in_ready = {NCH{1'b0}};
    if (state_r == IDLE && found_s) begin
      in_ready[grant_s] = 1'b1;
    end else begin
      in_ready = {NCH{1'b0}};
    end
  end

  assign hs_s = (state_r == IDLE) && found_s;

  // Pick the tap/coefficient pair for the current MAC step and accumulate.
  always_comb begin
    case (state_r)
      MAC0: begin
        mul_x_s = x0_r[ch_r];
        mul_c_s = c0_r;
      end
      MAC1: begin
        mul_x_s = x1_r[ch_r];
        mul_c_s = c1_r;
      end
      MAC2: begin
        mul_x_s = x2_r[ch_r];
        mul_c_s = c2_r;
      end
      default: begin
        mul_x_s = 8'sd0;
        mul_c_s = 8'sd0;
      end
    endcase
    prod_s = mul_x_s * mul_c_s;
    sum_s  = acc_r + {{2{prod_s[15]}}, prod_s};
  end

  // Sequencer: grant, shift history, three MAC steps, then hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      for (int k = 0; k < NCH; k++) begin
        x0_r[k] <= 8'sd0;
        x1_r[k] <= 8'sd0;
        x2_r[k] <= 8'sd0;
      end
      c0_r      <= 8'sh40;
      c1_r      <= 8'sh40;
      c2_r      <= 8'sh40;
      last_r    <= wrap_idx({CHW{1'b0}}, NCH - 1);
      ch_r      <= {CHW{1'b0}};
      acc_r     <= 18'sd0;
      out_valid <= 1'b0;
      out_ch    <= {CHW{1'b0}};
      out_data  <= 16'h0000;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (coef_wr_en) begin
            case (coef_wr_addr)
              2'd0:    c0_r <= coef_wr_data;
              2'd1:    c1_r <= coef_wr_data;
              2'd2:    c2_r <= coef_wr_data;
              default: c0_r <= c0_r;
            endcase
          end
          if (hs_s) begin
            x2_r[grant_s] <= x1_r[grant_s];
            x1_r[grant_s] <= x0_r[grant_s];
            x0_r[grant_s] <= in_data[{grant_s, 3'b000} +: 8];
            ch_r          <= grant_s;
            last_r        <= grant_s;
            acc_r         <= 18'sd0;
            busy          <= 1'b1;
            state_r       <= MAC0;
          end
        end
        MAC0: begin
          acc_r   <= sum_s;
          state_r <= MAC1;
        end
        MAC1: begin
          acc_r   <= sum_s;
          state_r <= MAC2;
        end
        MAC2: begin
          acc_r     <= sum_s;
`ifdef FIR_TDM_SAT_EN
          out_data  <= sat16(sum_s);
`else
          out_data  <= sum_s[15:0];
`endif
          out_ch    <= ch_r;
          out_valid <= 1'b1;
          state_r   <= OUTS;
        end
        OUTS: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tdm_sched.sv
// Scoreboard bench for fir_tdm_sched: a transaction-level model predicts
// grants and filter results; a negedge monitor compares the DUT against it.
module tb_fir_tdm_sched;

  localparam int NCH = 4;
  localparam int CHW = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NCH-1:0]     in_valid;
  logic [8*NCH-1:0]   in_data;
  logic [NCH-1:0]     in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [CHW-1:0]     out_ch;
  logic [15:0]        out_data;
  logic               coef_wr_en;
  logic [1:0]         coef_wr_addr;
  logic [7:0]         coef_wr_data;
  logic               busy;

  fir_tdm_sched #(.NCH(NCH), .CHW(CHW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int ch; int data;} exp_t;
  exp_t sbq[$];

  int           hist[NCH][3];
  int           coef[3];
  int           last_m;
  bit           inflight_m;
  int           hs_cyc_m;
  int           cyc;
  bit [NCH-1:0] hs_flag_m;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
  endtask

  function automatic int s8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // Output narrowing of the mathematical filter sum to 16 bits.
  function automatic int narrow_m(input int y);
    int v;
    v = y;
`ifdef FIR_TDM_SAT_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    return v & 32'h0000FFFF;
  endfunction

  function automatic int pick_grant(input logic [NCH-1:0] v, input int last);
    for (int i = 1; i <= NCH; i++) begin
      if (v[(last + i) % NCH]) return (last + i) % NCH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) for (int t = 0; t < 3; t++) hist[c][t] = 0;
    for (int t = 0; t < 3; t++) coef[t] = 64;
    last_m = NCH - 1;
    inflight_m = 1'b0;
    hs_flag_m = '0;
    sbq.delete();
  endtask

  // Transaction model, advanced once per rising edge with the inputs seen there.
  task automatic model_step();
    int g;
    int y;
    bit hs;
    hs = 1'b0;
    hs_flag_m = '0;
    if (!rst_n) begin
      model_reset();
    end else if (inflight_m) begin
      if (cyc >= hs_cyc_m + 3 && out_ready) inflight_m = 1'b0;
    end else begin
      if (coef_wr_en && coef_wr_addr != 2'd3) coef[coef_wr_addr] = s8(coef_wr_data);
      g = pick_grant(in_valid, last_m);
      if (g >= 0) begin
        hist[g][2] = hist[g][1];
        hist[g][1] = hist[g][0];
        hist[g][0] = s8(in_data[8*g +: 8]);
        y = coef[0]*hist[g][0] + coef[1]*hist[g][1] + coef[2]*hist[g][2];
        sbq.push_back('{ch: g, data: narrow_m(y)});
        last_m = g;
        inflight_m = 1'b1;
        hs_flag_m[g] = 1'b1;
        hs = 1'b1;
      end
    end
    cyc++;
    if (hs) hs_cyc_m = cyc;
  endtask

  // Monitor: compare handshake, status and results against the model.
  task automatic monitor_step();
    int g;
    logic [NCH-1:0] exp_ready;
    bit ov_m;
    exp_t e;
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
    end else begin
      exp_ready = '0;
      if (!inflight_m) begin
        g = pick_grant(in_valid, last_m);
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(inflight_m));
      ov_m = inflight_m && (cyc >= hs_cyc_m + 3);
      chk("out_valid", 32'(out_valid), 32'(ov_m));
      if (out_valid) begin
        chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          e = sbq[0];
          chk("out_ch", 32'(out_ch), 32'(e.ch));
          chk("out_data", 32'(out_data), 32'(e.data));
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  endtask

  initial begin
    cyc = 0;
    hs_cyc_m = 0;
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      monitor_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    in_data[8*ch +: 8] = d;
    in_valid[ch] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (hs_flag_m[ch]) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid[ch] = 1'b0;
    chk("send_handshake", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (!inflight_m) break;
      tick();
    end
    chk("idle_reached", 32'(inflight_m), 32'd0);
  endtask

  task automatic wr_coef(input logic [1:0] a, input logic [7:0] d);
    coef_wr_en = 1'b1;
    coef_wr_addr = a;
    coef_wr_data = d;
    tick();
    coef_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b1;
    coef_wr_en = 1'b0;
    coef_wr_addr = 2'd0;
    coef_wr_data = 8'h00;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Default coefficients, channel 0 ramp.
    send(0, 8'h20); wait_idle();
    send(0, 8'h40); wait_idle();
    send(0, 8'h60); wait_idle();

    // All channels requesting: round-robin order from channel 0.
    do_reset();
    in_data = $urandom;
    in_valid = {NCH{1'b1}};
    repeat (26) begin
      tick();
      in_data = $urandom;
    end
    in_valid = '0;
    wait_idle();

    // Coefficient programming, write while busy, ignored address 3.
    wr_coef(2'd0, 8'h40);
    wr_coef(2'd1, 8'h00);
    wr_coef(2'd2, 8'h00);
    send(1, 8'h30); wait_idle();
    send(2, 8'h25);
    wr_coef(2'd1, 8'h7F);
    wr_coef(2'd2, 8'h7F);
    wait_idle();
    wr_coef(2'd3, 8'h11);
    send(2, 8'h10); wait_idle();

    // Write coincident with a handshake applies to that sample.
    in_data[8*3 +: 8] = 8'h18;
    in_valid[3] = 1'b1;
    coef_wr_en = 1'b1;
    coef_wr_addr = 2'd0;
    coef_wr_data = 8'h20;
    tick();
    coef_wr_en = 1'b0;
    in_valid[3] = 1'b0;
    chk("coincident_hs", 32'(hs_flag_m[3]), 32'd1);
    wait_idle();

    // Full-scale positive and negative sums.
    wr_coef(2'd0, 8'h7F);
    wr_coef(2'd1, 8'h7F);
    wr_coef(2'd2, 8'h7F);
    repeat (3) begin send(3, 8'h7F); wait_idle(); end
    repeat (3) begin send(3, 8'h80); wait_idle(); end

    // Back-pressure in OUT with another channel waiting.
    out_ready = 1'b0;
    send(1, 8'h11);
    in_data[8*0 +: 8] = 8'h05;
    in_valid[0] = 1'b1;
    repeat (6) tick();
    out_ready = 1'b1;
    send(0, 8'h05);
    wait_idle();

    // Reset during MAC1 clears in-flight work and history.
    send(0, 8'h55);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send(0, 8'h20); wait_idle();

    // Random traffic, back-pressure and coefficient writes.
    for (int n = 0; n < 500; n++) begin
      in_valid = NCH'($urandom);
      in_data = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      coef_wr_en = ($urandom_range(0, 7) == 0);
      coef_wr_addr = 2'($urandom);
      coef_wr_data = 8'($urandom);
      tick();
    end
    in_valid = '0;
    out_ready = 1'b1;
    coef_wr_en = 1'b0;
    wait_idle();
    repeat (3) tick();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fir_tdm_sched.md
Name: fir_tdm_sched

Overview:
Time-multiplexed scheduler that shares one 3-tap FIR multiply-accumulate datapath among NCH independent sample channels. It holds a per-channel delay line and a shared programmable coefficient set. It arbitrates channel requests round-robin and sequences one product per cycle. It returns each filtered result with its channel tag over a valid/ready output. It sits between the per-channel sample sources and the downstream consumer, and replaces NCH copies of a single-channel 3-tap FIR.

Parameters:
NCH, 4, number of input channels (2..8)
CHW, 2, channel-index width, must equal clog2(NCH)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  NCH  per-channel sample valid
in_data  in  8*NCH  per-channel sample, signed Q3.4; channel k occupies bits [8k+7:8k]
in_ready  out  NCH  per-channel accept; one-hot or zero
out_valid  out  1  result valid
out_ready  in  1  consumer accept
out_ch  out  CHW  channel index of the result
out_data  out  16  result, signed Q5.10
coef_wr_en  in  1  coefficient write strobe
coef_wr_addr  in  2  tap select 0..2; 3 is ignored
coef_wr_data  in  8  coefficient, signed Q1.6
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Filter: y = c0*x[n] + c1*x[n-1] + c2*x[n-2], evaluated per channel on that channel's own history.
- Arithmetic width: each Q3.4 x Q1.6 product is a 16-bit Q5.10 value. The accumulator is 18-bit signed. Narrowing to 16 bits is set by the optional feature.
- Reset values (async, on rst_n low):
  - FSM = IDLE.
  - All delay lines = 0.
  - c0 = c1 = c2 = 8'h40 (1.0).
  - Round-robin pointer last = NCH-1, so the first grant goes to channel 0.
  - out_valid = 0, out_ch = 0, out_data = 0, in_ready = 0, busy = 0.
- FSM states: IDLE -> MAC0 -> MAC1 -> MAC2 -> OUT -> IDLE.
- IDLE:
  - grant = first channel with in_valid high, searching from last+1 with wrap.
  - in_ready[grant] is asserted combinationally; it is never asserted with no valid request.
  - On handshake: shift the granted channel's delay line (x2<=x1, x1<=x0, x0<=in_data), latch the channel index, set last <= grant, clear the accumulator, go to MAC0.
- MAC0/MAC1/MAC2: add c0*x0, c1*x1, c2*x2 respectively, one product per cycle.
- OUT:
  - out_valid = 1; out_data and out_ch are registered and held stable until out_ready.
  - On out_valid & out_ready: go to IDLE next cycle.
- Timing:
  - Latency: handshake in cycle T, out_valid asserted in cycle T+4.
  - Peak throughput: 1 sample per 5 cycles.
  - No new in_ready is issued while not in IDLE.
- in_valid may drop without handshake; no state change results.
- Coefficient writes:
  - Accepted only in IDLE. A write while busy = 1 is dropped silently.
  - A write coincident with an input handshake in IDLE takes effect for that same sample.
  - coef_wr_addr = 3 is ignored.
- Reset mid-operation: the in-flight sample is discarded and out_valid drops immediately.

Optional Feature:
FIR_TDM_SAT_EN
- Defined: the 18-bit accumulator is saturated to 16-bit signed; values > 32767 become 16'h7FFF and values < -32768 become 16'h8000.
- Undefined: out_data = accumulator[15:0] (two's-complement wrap), with no saturation logic present.

Test Plan:
- Reset with default coefficients; channel 0 sends 8'h20, 8'h40, 8'h60 (2, 4, 6), out_ready = 1 -> out_data = 16'h0800, 16'h1800, 16'h3000, out_ch = 0, each 4 cycles after its handshake.
- After reset, all 4 in_valid held high with distinct samples -> grants in order ch0, ch1, ch2, ch3, ch0; out_ch follows the same order; in_ready is never multi-hot.
- Write c0 = 8'h40, c1 = 0, c2 = 0 in IDLE; send 8'h30 -> out_data = 16'h0C00. Repeat the write while busy -> it is ignored and the coefficients are unchanged.
- Set all coefficients to 8'h7F; send 8'h7F three times on one channel -> third result = 16'h7FFF with FIR_TDM_SAT_EN, 16'hBD03 without. Same with samples 8'h80 -> 16'h8000 with FIR_TDM_SAT_EN.
- Hold out_ready low for 3 cycles in OUT -> out_valid, out_data and out_ch stay stable, all in_ready stay 0; accepted on the 4th cycle, then the next grant is issued.
- Assert rst_n low during MAC1 -> out_valid = 0 and busy = 0 immediately; the next sample on that channel sees a zeroed history (8'h20 -> 16'h0800).
